// File: rtl/nrzi_pkg.sv
// Shared state type and line constants for the NRZI bit-stuffing transmit encoder.
package nrzi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_e;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic       LEVEL_J      = 1'b1;
  localparam logic       LEVEL_K      = 1'b0;

endpackage

// File: rtl/nrzi_line_coder.sv
// Registered NRZI line level: a 0 toggles the level, a 1 holds it; SE0 and J can be forced.
module nrzi_line_coder
  import nrzi_pkg::*;
(
  input  logic clk,
  input  logic rst_i,
  input  logic bit_en_i,
  input  logic toggle_i,
  input  logic force_se0_i,
  input  logic force_j_i,
  output logic line_bit_o,
  output logic line_se0_o
);

  logic level_q, level_d;
  logic se0_q, se0_d;

  always_comb begin
    level_d = level_q;
    se0_d   = se0_q;
    if (bit_en_i) begin
      if (force_j_i) begin
        level_d = LEVEL_J;
        se0_d   = 1'b0;
      end else if (force_se0_i) begin
        se0_d   = 1'b1;
      end else begin
        level_d = level_q ^ toggle_i;
        se0_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      level_q <= LEVEL_J;
      se0_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      se0_q   <= se0_d;
    end
  end

  // The held NRZI level is masked to K while SE0 is on the line.
  assign line_bit_o = level_q & ~se0_q;
  assign line_se0_o = se0_q;

endmodule

// File: rtl/nrzi_stuff_encoder.sv
// USB-style transmit encoder: word buffer, LSB-first shifter, bit stuffing, NRZI and EOP.
// Optional SYNC generation is enabled by defining NRZI_SYNC_GEN_EN.
//
// state   | meaning
// IDLE    | line held at J, waiting for a buffered word
// SYNC    | sending SYNC_PATTERN bits ahead of the first word
// DATA    | sending data bit bit_cnt_q of the current word
// STUFF   | sending an inserted 0 after STUFF_LIMIT ones
// EOP_SE0 | sending SE0 bit times
// EOP_J   | sending the closing J bit
module nrzi_stuff_encoder
  import nrzi_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              bit_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              line_bit,
  output logic              line_se0,
  output logic              tx_active,
  output logic              underrun
);

  localparam int BW = $clog2(DATA_W);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int EW = $clog2(EOP_SE0_BITS + 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] buf_q, sh_q, sh_d;
  logic              buf_last_q, buf_valid_q, last_q, last_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [OW-1:0]     ones_q, ones_d;
  logic [EW-1:0]     eop_cnt_q, eop_cnt_d;
  logic [2:0]        sync_cnt_q, sync_cnt_d, sync_nxt;
  logic              in_sync_q, in_sync_d;
  logic              tx_active_q, tx_active_d, underrun_q, underrun_d;
  logic              fill, pull, adv, send, send_bit, force_se0, force_j;

  assign fill     = in_valid & ~buf_valid_q;
  assign sync_nxt = sync_cnt_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    last_d      = last_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    eop_cnt_d   = eop_cnt_q;
    sync_cnt_d  = sync_cnt_q;
    in_sync_d   = in_sync_q;
    tx_active_d = tx_active_q;
    underrun_d  = 1'b0;
    pull        = 1'b0;
    adv         = 1'b0;
    send        = 1'b0;
    send_bit    = 1'b1;
    force_se0   = 1'b0;
    force_j     = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          force_j = 1'b1;
          if (buf_valid_q) begin
            force_j     = 1'b0;
            pull        = 1'b1;
            send        = 1'b1;
            sh_d        = buf_q;
            last_d      = buf_last_q;
            bit_cnt_d   = '0;
            tx_active_d = 1'b1;
`ifdef NRZI_SYNC_GEN_EN
            state_d     = SYNC;
            in_sync_d   = 1'b1;
            sync_cnt_d  = '0;
            send_bit    = SYNC_PATTERN[0];
`else
            state_d     = DATA;
            send_bit    = buf_q[0];
`endif
          end
        end
        SYNC, DATA: begin
          if (ones_q == OW'(STUFF_LIMIT)) begin
            state_d  = STUFF;
            send     = 1'b1;
            send_bit = 1'b0;
          end else begin
            adv = 1'b1;
          end
        end
        STUFF: adv = 1'b1;
        EOP_SE0: begin
          if (eop_cnt_q == EW'(EOP_SE0_BITS - 1)) begin
            state_d = EOP_J;
            force_j = 1'b1;
          end else begin
            eop_cnt_d = eop_cnt_q + EW'(1);
            force_se0 = 1'b1;
          end
        end
        EOP_J: begin
          state_d     = IDLE;
          force_j     = 1'b1;
          tx_active_d = 1'b0;
          ones_d      = '0;
        end
        default: begin
          state_d = IDLE;
          force_j = 1'b1;
        end
      endcase

      // Step to whatever follows the bit just completed (sync bit, data bit, next word or EOP).
      if (adv) begin
        if (in_sync_q) begin
          send = 1'b1;
          if (sync_cnt_q == 3'd7) begin
            in_sync_d = 1'b0;
            state_d   = DATA;
            bit_cnt_d = '0;
            send_bit  = sh_q[0];
          end else begin
            state_d    = SYNC;
            sync_cnt_d = sync_nxt;
            send_bit   = SYNC_PATTERN[sync_nxt];
          end
        end else if (bit_cnt_q != BW'(DATA_W - 1)) begin
          send      = 1'b1;
          state_d   = DATA;
          sh_d      = sh_q >> 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          send_bit  = sh_q[1];
        end else if (!last_q && buf_valid_q) begin
          send      = 1'b1;
          pull      = 1'b1;
          state_d   = DATA;
          sh_d      = buf_q;
          last_d    = buf_last_q;
          bit_cnt_d = '0;
          send_bit  = buf_q[0];
        end else begin
          underrun_d = ~last_q;
          state_d    = EOP_SE0;
          eop_cnt_d  = '0;
          force_se0  = 1'b1;
        end
      end

      if (send) ones_d = send_bit ? ones_q + OW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      buf_last_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      sh_q        <= '0;
      last_q      <= 1'b0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      eop_cnt_q   <= '0;
      sync_cnt_q  <= '0;
      in_sync_q   <= 1'b0;
      tx_active_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      last_q      <= last_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      eop_cnt_q   <= eop_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      in_sync_q   <= in_sync_d;
      tx_active_q <= tx_active_d;
      underrun_q  <= underrun_d;
      if (pull) buf_valid_q <= 1'b0;
      if (fill) begin
        buf_valid_q <= 1'b1;
        buf_q       <= in_data;
        buf_last_q  <= in_last;
      end
    end
  end

  nrzi_line_coder u_coder (
    .clk        (clk),
    .rst_i      (RST),
    .bit_en_i   (bit_en),
    .toggle_i   (send & ~send_bit),
    .force_se0_i(force_se0),
    .force_j_i  (force_j),
    .line_bit_o (line_bit),
    .line_se0_o (line_se0)
  );

  assign in_ready  = ~buf_valid_q;
  assign tx_active = tx_active_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_nrzi_stuff_encoder.sv
// Directed bench for nrzi_stuff_encoder; line symbols: K, J (active), I (idle J), S (SE0), U (SE0 with underrun).
module tb_nrzi_stuff_encoder;

  logic       clk = 1'b0;
  logic       RST;
  logic       bit_en;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready, line_bit, line_se0, tx_active, underrun;

  int n_pass  = 0;
  int n_total = 0;

  nrzi_stuff_encoder #(.DATA_W(8), .STUFF_LIMIT(6), .EOP_SE0_BITS(2)) dut (
    .clk      (clk),
    .RST      (RST),
    .bit_en   (bit_en),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .line_bit (line_bit),
    .line_se0 (line_se0),
    .tx_active(tx_active),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  function automatic byte line_char();
    if (line_se0 && line_bit) return "?";
    if (line_se0) return underrun ? (tx_active ? "U" : "u") : (tx_active ? "S" : "s");
    if (underrun) return "!";
    if (!line_bit) return tx_active ? "K" : "k";
    return tx_active ? "J" : "I";
  endfunction

  task automatic chk_c(input string tag, input byte obs, input byte exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%c expected=%c", tag, obs, exp);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic put_word(input logic [7:0] d, input logic l);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_b("put_in_ready", in_ready, 1'b0);
  endtask

  // One symbol per bit_en edge (every p cycles); between edges the line must hold.
  // A word (fd, fl) is offered on the edge of symbol feed_at.
  task automatic expect_line(input string tag, input string exp, input int p,
                             input int feed_at, input logic [7:0] fd, input logic fl);
    for (int i = 0; i < exp.len(); i++) begin
      for (int h = 1; h < p; h++) begin
        bit_en = 1'b0;
        @(posedge clk); #1;
        if (i > 0) chk_c($sformatf("%s_hold%0d", tag, i - 1), line_char(), exp[i-1]);
      end
      bit_en = 1'b1;
      if (i == feed_at) begin
        in_data  = fd;
        in_last  = fl;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bit_en = 1'b0;
      if (i == feed_at) begin
        in_valid = 1'b0;
        chk_b($sformatf("%s_feed_ready", tag), in_ready, 1'b0);
      end
      chk_c($sformatf("%s_sym%0d", tag, i), line_char(), exp[i]);
    end
    bit_en = 1'b0;
  endtask

  initial begin
    RST      = 1'b1;
    bit_en   = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    chk_c("reset_line", line_char(), "I");
    chk_b("reset_in_ready", in_ready, 1'b1);
    chk_b("reset_underrun", underrun, 1'b0);

    // T1: reset mid-packet aborts with no EOP
    put_word(8'h00, 1'b1);
    expect_line("t1_pre", "KJK", 1, -1, 8'h00, 1'b0);
    RST    = 1'b1;
    bit_en = 1'b1;
    @(posedge clk); #1;
    RST    = 1'b0;
    bit_en = 1'b0;
    chk_c("t1_after_rst", line_char(), "I");
    chk_b("t1_in_ready", in_ready, 1'b1);
    expect_line("t1_idle", "IIII", 1, -1, 8'h00, 1'b0);

`ifdef NRZI_SYNC_GEN_EN
    // T4: sync KJKJKJKK, then 8'h00 toggles from K
    put_word(8'h00, 1'b1);
    expect_line("t4", "KJKJKJKKJKJKJKJKSSJI", 1, -1, 8'h00, 1'b0);
`else
    // T2: 8'h00 alternates every bit
    put_word(8'h00, 1'b1);
    expect_line("t2", "KJKJKJKJSSJII", 1, -1, 8'h00, 1'b0);

    // T3: 8'hFF stuffs after six ones, stuff toggles to K
    put_word(8'hFF, 1'b1);
    expect_line("t3", "JJJJJJKKKSSJI", 1, -1, 8'h00, 1'b0);

    // T5: non-last word with no follow-up underruns; late word starts a new packet
    put_word(8'h0F, 1'b0);
    expect_line("t5", "JJJJKJKJUSJIJKJKJKJKSSJI", 1, 9, 8'h01, 1'b1);

    // T6: bit_en every 4th cycle, 8'h7E then 8'hFF last
    put_word(8'h7E, 1'b0);
    expect_line("t6", "KKKKKKKJKKKKKKKJJJSSJI", 4, 2, 8'hFF, 1'b1);

    // T7: ones run 8'hF0 -> 8'h03 crosses the word boundary before stuffing
    put_word(8'hF0, 1'b0);
    expect_line("t7", "KJKJJJJJJJKJKJKJKSSJI", 1, 2, 8'h03, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
